// File: rtl/speed_sample_ctrl.sv
`timescale 1ns/1ps
// speed_sample_ctrl: sequences flush and warm-up of the encoder period datapath,
// samples its averaged count at a programmable rate and detects a stopped shaft.
module speed_sample_ctrl #(
    parameter int CNT_W        = 31,
    parameter int PER_W        = 24,
    parameter int WARMUP_EDGES = 4,
    parameter int STALL_LIMIT  = 8,
    parameter int FLUSH_CYC    = 2
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             en,
    input  logic [PER_W-1:0] period_cfg,
    input  logic             meas_edge,
    input  logic [CNT_W-1:0] meas_speed,
    input  logic             meas_dir,
    output logic             meas_rst_n,
    output logic [CNT_W-1:0] smp_speed,
    output logic             smp_dir,
    output logic             smp_stalled,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic             ovr_flag,
    input  logic             ovr_clr,
    output logic [2:0]       state_o
);

    localparam int EC_W = $clog2(WARMUP_EDGES + 1);
    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [EC_W-1:0] EDGE_LAST  = EC_W'(WARMUP_EDGES - 1);
    localparam logic [SC_W-1:0] STALL_LIM  = SC_W'(STALL_LIMIT);
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        WARMUP = 3'd2,
        RUN    = 3'd3,
        STALL  = 3'd4
    } state_t;

    state_t             state_q;
    logic               meas_rst_n_q;
    logic [PER_W-1:0]   per_lat_q;
    logic [PER_W-1:0]   per_cnt_q;
    logic [FC_W-1:0]    flush_cnt_q;
    logic [EC_W-1:0]    edge_cnt_q;
    logic [SC_W-1:0]    stale_q;
    logic               edge_seen_q;

    logic [CNT_W-1:0]   smp_speed_q;
    logic               smp_dir_q;
    logic               smp_stalled_q;
    logic               smp_valid_q;
    logic               ovr_q;

    logic               active;
    logic               tick;
    logic               edge_any;
    logic [SC_W-1:0]    stale_d;
    logic               stall_hit;
    logic               load;
    logic               ovr_set;
    logic [CNT_W-1:0]   ld_speed;
    logic               ld_dir;
    logic               ld_stalled;

    // An edge on the tick cycle still belongs to the period that is closing.
    always_comb begin
        active     = (state_q == WARMUP) || (state_q == RUN) || (state_q == STALL);
        tick       = active && (per_cnt_q == (per_lat_q - 1'b1));
        edge_any   = edge_seen_q || meas_edge;
        stale_d    = stale_q;
        if (tick) begin
            if (edge_any) begin
                stale_d = '0;
            end else if (stale_q != STALL_LIM) begin
                stale_d = stale_q + 1'b1;
            end
        end
        stall_hit  = tick && !edge_any && (stale_d == STALL_LIM);
        load       = en && tick && ((state_q == RUN) || (state_q == STALL));
        ovr_set    = load && smp_valid_q && !smp_ready;
        ld_stalled = (state_q == STALL) || stall_hit;
        ld_speed   = ld_stalled ? '0 : meas_speed;
        ld_dir     = (state_q == RUN) ? meas_dir : smp_dir_q;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q      <= IDLE;
            meas_rst_n_q <= 1'b0;
            per_lat_q    <= '0;
            per_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            edge_cnt_q   <= '0;
            stale_q      <= '0;
            edge_seen_q  <= 1'b0;
        end else if (!en) begin
            state_q      <= IDLE;
            meas_rst_n_q <= 1'b0;
            per_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            edge_cnt_q   <= '0;
            stale_q      <= '0;
            edge_seen_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    per_lat_q   <= (period_cfg == '0) ? PER_W'(1) : period_cfg;
                    flush_cnt_q <= '0;
                    state_q     <= FLUSH;
                end
                FLUSH: begin
                    per_cnt_q   <= '0;
                    edge_cnt_q  <= '0;
                    stale_q     <= '0;
                    edge_seen_q <= 1'b0;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q      <= WARMUP;
                        meas_rst_n_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                WARMUP, RUN, STALL: begin
                    per_cnt_q   <= tick ? '0 : per_cnt_q + 1'b1;
                    edge_seen_q <= !tick && edge_any;
                    stale_q     <= stale_d;
                    if (state_q == WARMUP) begin
                        if (meas_edge) begin
                            edge_cnt_q <= edge_cnt_q + 1'b1;
                        end
                        if (meas_edge && (edge_cnt_q == EDGE_LAST)) begin
                            state_q <= RUN;
                        end else if (stall_hit) begin
                            state_q <= STALL;
                        end
                    end else if (state_q == RUN) begin
                        if (stall_hit) begin
                            state_q <= STALL;
                        end
                    end else if (meas_edge) begin
                        // Shaft moving again: purge the stale averages before trusting them.
                        state_q      <= FLUSH;
                        meas_rst_n_q <= 1'b0;
                        flush_cnt_q  <= '0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    meas_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    // Single holding register; a load coincident with a handshake is not an overrun.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            smp_speed_q   <= '0;
            smp_dir_q     <= 1'b0;
            smp_stalled_q <= 1'b0;
            smp_valid_q   <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
            if (!en) begin
                smp_valid_q <= 1'b0;
            end else if (load) begin
                smp_speed_q   <= ld_speed;
                smp_dir_q     <= ld_dir;
                smp_stalled_q <= ld_stalled;
                smp_valid_q   <= 1'b1;
            end else if (smp_valid_q && smp_ready) begin
                smp_valid_q <= 1'b0;
            end
        end
    end

    assign meas_rst_n  = meas_rst_n_q;
    assign smp_speed   = smp_speed_q;
    assign smp_dir     = smp_dir_q;
    assign smp_stalled = smp_stalled_q;
    assign smp_valid   = smp_valid_q;
    assign ovr_flag    = ovr_q;
    assign state_o     = state_q;

endmodule
